// File: rtl/event_irq_scheduler_if.sv
// event_irq_scheduler_if: AHB-Lite slave bus bundle for the event IRQ scheduler
interface event_irq_scheduler_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  modport master (output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS, input HRDATA, HREADYOUT);
  modport slave (input HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS, output HRDATA, HREADYOUT);
endinterface

// File: rtl/event_irq_scheduler.sv
// event_irq_scheduler: latches event pulses, round-robin picks one and raises a gap-limited IRQ
module event_irq_scheduler #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  event_irq_scheduler_if.slave bus,
  input  logic [N_SRC-1:0]     EventPulse,
  output logic                 IRQ
);
  localparam int IDW = $clog2(N_SRC);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2} state_t;
  state_t state, state_n;
  logic [N_SRC-1:0] pending, enable, req, clr;
  logic [IDW-1:0] active_id, rr_ptr, pick, rr_next;
  logic [GW-1:0] gap_cnt;
  logic a_valid, a_write, ack, en_wr, unused;
  logic [2:0] a_idx;
  function automatic logic [IDW-1:0] idx_of(input logic [IDW-1:0] base, input int k);
    return IDW'(int'(base) + k >= N_SRC ? int'(base) + k - N_SRC : int'(base) + k);
  endfunction
  assign req     = pending & enable;
  assign ack     = a_valid && a_write && a_idx == 3'd3 && state == ASSERT;
  assign en_wr   = a_valid && a_write && a_idx == 3'd1;
  assign clr     = ack ? N_SRC'(1) << active_id : '0;
  assign rr_next = active_id == IDW'(N_SRC - 1) ? '0 : active_id + 1'b1;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRDATA = a_idx == 3'd0 ? 32'(pending) :
                      a_idx == 3'd1 ? 32'(enable) :
                      a_idx == 3'd2 ? {state == ASSERT, 31'(active_id)} :
                      a_idx == 3'd4 ? 32'(state) : '0;
  assign unused = &{1'b0, bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:N_SRC]};
  // lowest offset from rr_ptr wins, so scan downward and let later hits override
  always_comb begin
    pick = rr_ptr;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (req[idx_of(rr_ptr, k)]) pick = idx_of(rr_ptr, k);
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && |req) ? ASSERT :
              ack ? GAP :
              (state == GAP && gap_cnt == '0) ? IDLE : state;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      IRQ   <= 1'b0;
    end else begin
      state <= state_n;
      IRQ   <= state_n == ASSERT;
    end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pending   <= '0;
      enable    <= '0;
      active_id <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_idx     <= '0;
    end else begin
      pending <= (pending & ~clr) | EventPulse;
      if (en_wr) enable <= bus.HWDATA[N_SRC-1:0];
      if (state == IDLE && |req) active_id <= pick;
      if (ack) begin
        rr_ptr  <= rr_next;
        gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (bus.HREADY) begin
        a_valid <= bus.HSEL && bus.HTRANS != 2'b00;
        a_write <= bus.HWRITE;
        a_idx   <= bus.HADDR[4:2];
      end
    end
endmodule
